// File: rtl/bw_test_pkg.sv
// ---------------------------------------------------------------------------
// bw_test_pkg
// Shared definitions for the AXI-Stream bandwidth tester:
//   LANE_W        width of one pattern lane inside TDATA
//   tx_state_t    generator FSM states
//   sat_inc       saturating increment for counters/timers up to 64 bits
//   pattern_lane  value carried by one lane for a given beat index
// ---------------------------------------------------------------------------
package bw_test_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    // Callers widen their counter to 64 bits and truncate the result back.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

    // Lane 'lane' of beat 'base' carries base + lane, wrapping at 32 bits.
    function automatic logic [LANE_W-1:0] pattern_lane(input logic [LANE_W-1:0] base,
                                                       input int unsigned       lane);
        return base + LANE_W'(lane);
    endfunction

endpackage

// File: rtl/axis_seq_checker.sv
// ---------------------------------------------------------------------------
// axis_seq_checker
// Receive-side statistics for the bandwidth tester.
//   clock, resetn   clock and internally synchronised active-low reset
//   clear           one-cycle pulse from an accepted start: restart statistics
//   beat_valid      an IN stream handshake happens this cycle
//   beat_last       TLAST of the handshaking beat
//   beat_data       TDATA of the handshaking beat
//   rx_beats        handshakes since the last clear (saturating)
//   rx_errors       beats whose pattern mismatched (saturating)
//   rx_first_err    expected index of the first mismatching beat, all-ones if none
//   rx_time         cycles from first handshake to TLAST handshake, inclusive
// Optional feature: define BW_TEST_RX_CHECK_EN to build the pattern
// comparators; without it rx_errors is 0 and rx_first_err is all-ones.
// ---------------------------------------------------------------------------
module axis_seq_checker
    import bw_test_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int COUNT_WIDTH = 32,
    parameter int TIME_WIDTH  = 64
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   beat_valid,
    input  logic                   beat_last,
    input  logic [DATA_WIDTH-1:0]  beat_data,
    output logic [COUNT_WIDTH-1:0] rx_beats,
    output logic [COUNT_WIDTH-1:0] rx_errors,
    output logic [COUNT_WIDTH-1:0] rx_first_err,
    output logic [TIME_WIDTH-1:0]  rx_time
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_W;

    // timing: burst in flight, rx_time counting every cycle.
    // timed:  TLAST already seen, rx_time frozen until the next clear.
    logic timing;
    logic timed;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_beats <= '0;
            rx_time  <= '0;
            timing   <= 1'b0;
            timed    <= 1'b0;
        end else if (clear) begin
            rx_beats <= '0;
            rx_time  <= '0;
            timing   <= 1'b0;
            timed    <= 1'b0;
        end else begin
            if (beat_valid)
                rx_beats <= COUNT_WIDTH'(sat_inc(64'(rx_beats), COUNT_WIDTH));

            if (timing) begin
                rx_time <= TIME_WIDTH'(sat_inc(64'(rx_time), TIME_WIDTH));
                if (beat_valid && beat_last) begin
                    timing <= 1'b0;
                    timed  <= 1'b1;
                end
            end else if (beat_valid && !timed) begin
                rx_time <= TIME_WIDTH'(1);
                // A single-beat burst starts and finishes in the same cycle.
                if (beat_last)
                    timed <= 1'b1;
                else
                    timing <= 1'b1;
            end
        end
    end

`ifdef BW_TEST_RX_CHECK_EN
    logic [COUNT_WIDTH-1:0] exp_idx;
    logic [DATA_WIDTH-1:0]  exp_data;
    logic                   mismatch;

    always_comb begin
        exp_data = '0;
        for (int unsigned i = 0; i < LANES; i++)
            exp_data[i*LANE_W +: LANE_W] = pattern_lane(LANE_W'(exp_idx), i);
    end

    assign mismatch = (beat_data != exp_data);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_errors    <= '0;
            rx_first_err <= '1;
            exp_idx      <= '0;
        end else if (clear) begin
            rx_errors    <= '0;
            rx_first_err <= '1;
            exp_idx      <= '0;
        end else if (beat_valid) begin
            if (mismatch) begin
                rx_errors <= COUNT_WIDTH'(sat_inc(64'(rx_errors), COUNT_WIDTH));
                if (&rx_first_err)
                    rx_first_err <= exp_idx;
            end
            // The sender restarts its sequence after every TLAST.
            exp_idx <= beat_last ? '0 : exp_idx + COUNT_WIDTH'(1);
        end
    end
`else
    logic unused_data;
    assign unused_data  = ^beat_data;
    assign rx_errors    = '0;
    assign rx_first_err = '1;
`endif

endmodule

// File: rtl/axis_bw_tester.sv
// ---------------------------------------------------------------------------
// axis_bw_tester
// AXI-Stream bandwidth generator/checker for QSFP loopback links.
// The TX side sends beat_count beats of a per-lane sequence (lane i of beat
// n = n + i) with TLAST on the final beat and times the burst; the RX side
// (axis_seq_checker) checks the returning pattern and times it.
// Ports:
//   clock, resetn          clock, asynchronous active-low reset
//   start, beat_count      rising edge of start launches beat_count beats
//   busy, tx_done          burst in progress / final-beat pulse
//   xfer_time              TX cycles from first TVALID to final handshake
//   rx_time, rx_beats,
//   rx_errors, rx_first_err RX statistics since the last start
//   OUT_AXIS_*             generator stream
//   IN_AXIS_*              checker stream (always ready after reset)
// Optional feature: BW_TEST_RX_CHECK_EN enables the RX pattern comparators.
// ---------------------------------------------------------------------------
module axis_bw_tester
    import bw_test_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int COUNT_WIDTH = 32,
    parameter int TIME_WIDTH  = 64
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] beat_count,
    output logic                   busy,
    output logic                   tx_done,
    output logic [TIME_WIDTH-1:0]  xfer_time,
    output logic [TIME_WIDTH-1:0]  rx_time,
    output logic [COUNT_WIDTH-1:0] rx_beats,
    output logic [COUNT_WIDTH-1:0] rx_errors,
    output logic [COUNT_WIDTH-1:0] rx_first_err,
    output logic [DATA_WIDTH-1:0]  OUT_AXIS_TDATA,
    output logic                   OUT_AXIS_TVALID,
    output logic                   OUT_AXIS_TLAST,
    input  logic                   OUT_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]  IN_AXIS_TDATA,
    input  logic                   IN_AXIS_TVALID,
    input  logic                   IN_AXIS_TLAST,
    output logic                   IN_AXIS_TREADY
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_W;

    // Reset asserts asynchronously and releases on the first clock edge.
    // The same flop doubles as IN_AXIS_TREADY, which therefore rises on the
    // first cycle after release and stays high.
    logic rst_sync_n;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            rst_sync_n <= 1'b0;
        else
            rst_sync_n <= 1'b1;
    end

    assign IN_AXIS_TREADY = rst_sync_n;

    // ---- start edge detect ----
    tx_state_t              state;
    logic                   start_p1;
    logic                   start_edge;
    logic                   rx_clear;

    assign start_edge = start & ~start_p1;
    assign rx_clear   = start_edge && (state == IDLE);

    // ---- generator ----
    logic [COUNT_WIDTH-1:0] n_total;
    logic [COUNT_WIDTH-1:0] n_idx;
    logic [COUNT_WIDTH-1:0] n_next;
    logic [TIME_WIDTH-1:0]  timer;
    logic [DATA_WIDTH-1:0]  tdata_q;
    logic [DATA_WIDTH-1:0]  next_tdata;
    logic                   tvalid_q;
    logic                   tlast_q;
    logic                   busy_q;
    logic                   done_q;
    logic [TIME_WIDTH-1:0]  xfer_q;
    logic                   tx_hs;

    assign tx_hs  = tvalid_q & OUT_AXIS_TREADY;
    // In IDLE the next beat to present is beat 0; in RUN it is the successor.
    assign n_next = (state == IDLE) ? '0 : n_idx + COUNT_WIDTH'(1);

    always_comb begin
        next_tdata = '0;
        for (int unsigned i = 0; i < LANES; i++)
            next_tdata[i*LANE_W +: LANE_W] = pattern_lane(LANE_W'(n_next), i);
    end

    // TDATA/TLAST are registered and only reload on a handshake, so they
    // hold steady across back-pressure. timer already reads 1 in the first
    // TVALID cycle, so the value latched at the final handshake counts that
    // cycle too.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= IDLE;
            start_p1 <= 1'b0;
            n_total  <= '0;
            n_idx    <= '0;
            timer    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            xfer_q   <= '0;
        end else begin
            start_p1 <= start;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        if (beat_count != '0) begin
                            state    <= RUN;
                            busy_q   <= 1'b1;
                            n_total  <= beat_count;
                            n_idx    <= '0;
                            timer    <= TIME_WIDTH'(1);
                            tvalid_q <= 1'b1;
                            tdata_q  <= next_tdata;
                            tlast_q  <= (beat_count == COUNT_WIDTH'(1));
                        end else begin
                            done_q <= 1'b1;
                            xfer_q <= '0;
                        end
                    end
                end
                RUN: begin
                    if (tx_hs && tlast_q) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        done_q   <= 1'b1;
                        xfer_q   <= timer;
                    end else begin
                        timer <= TIME_WIDTH'(sat_inc(64'(timer), TIME_WIDTH));
                        if (tx_hs) begin
                            n_idx   <= n_next;
                            tdata_q <= next_tdata;
                            tlast_q <= (n_next == n_total - COUNT_WIDTH'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OUT_AXIS_TDATA  = tdata_q;
    assign OUT_AXIS_TVALID = tvalid_q;
    assign OUT_AXIS_TLAST  = tlast_q;
    assign busy            = busy_q;
    assign tx_done         = done_q;
    assign xfer_time       = xfer_q;

    // ---- checker ----
    axis_seq_checker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .TIME_WIDTH  (TIME_WIDTH)
    ) u_checker (
        .clock        (clock),
        .resetn       (rst_sync_n),
        .clear        (rx_clear),
        .beat_valid   (IN_AXIS_TVALID & IN_AXIS_TREADY),
        .beat_last    (IN_AXIS_TLAST),
        .beat_data    (IN_AXIS_TDATA),
        .rx_beats     (rx_beats),
        .rx_errors    (rx_errors),
        .rx_first_err (rx_first_err),
        .rx_time      (rx_time)
    );

endmodule

// File: tb/tb_axis_bw_tester.sv
// ---------------------------------------------------------------------------
// tb_axis_bw_tester
// Directed bench for axis_bw_tester with the generator looped back into the
// checker through a gate that models link back-pressure and a one-bit
// corruption injector. Expected RX error results follow BW_TEST_RX_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_axis_bw_tester;

    localparam int DW = 512;
    localparam int CW = 32;
    localparam int TW = 64;

`ifdef BW_TEST_RX_CHECK_EN
    localparam logic [63:0] EXP_CORR_ERRS  = 64'd1;
    localparam logic [63:0] EXP_CORR_FIRST = 64'd37;
`else
    localparam logic [63:0] EXP_CORR_ERRS  = 64'd0;
    localparam logic [63:0] EXP_CORR_FIRST = 64'hFFFF_FFFF;
`endif

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] beat_count = '0;
    logic          busy, tx_done;
    logic [TW-1:0] xfer_time, rx_time;
    logic [CW-1:0] rx_beats, rx_errors, rx_first_err;
    logic [DW-1:0] out_tdata, in_tdata;
    logic          out_tvalid, out_tlast, out_tready;
    logic          in_tvalid, in_tlast, in_tready;

    logic          gate = 1'b1;
    logic          corrupt_now = 1'b0;
    logic [DW-1:0] mask;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // Loopback: both sides of the link see the same gated handshake.
    assign out_tready = in_tready & gate;
    assign in_tvalid  = out_tvalid & gate;
    assign in_tlast   = out_tlast;
    assign in_tdata   = out_tdata ^ (corrupt_now ? mask : '0);

    axis_bw_tester #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW),
        .TIME_WIDTH  (TW)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .start           (start),
        .beat_count      (beat_count),
        .busy            (busy),
        .tx_done         (tx_done),
        .xfer_time       (xfer_time),
        .rx_time         (rx_time),
        .rx_beats        (rx_beats),
        .rx_errors       (rx_errors),
        .rx_first_err    (rx_first_err),
        .OUT_AXIS_TDATA  (out_tdata),
        .OUT_AXIS_TVALID (out_tvalid),
        .OUT_AXIS_TLAST  (out_tlast),
        .OUT_AXIS_TREADY (out_tready),
        .IN_AXIS_TDATA   (in_tdata),
        .IN_AXIS_TVALID  (in_tvalid),
        .IN_AXIS_TLAST   (in_tlast),
        .IN_AXIS_TREADY  (in_tready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch a burst of n beats and watch it at every falling edge.
    //   toggle      gate the link 1,0,1,0... from the first TVALID cycle
    //   corrupt_at  TX beat index whose lane 3 is flipped on the RX side (-1 none)
    //   restart_at  loop cycle where a second start edge is issued (-1 none)
    //   abort_at    return as soon as this many beats have handshaken (-1 none)
    task automatic burst(input int n, input bit toggle, input int corrupt_at,
                         input int restart_at, input int abort_at,
                         output int beats, output int pat_bad, output int hold_bad,
                         output int dones, output int late_valid);
        logic [DW-1:0] held_d;
        logic          held_l;
        bit            stalled;
        bit            phase;
        int            tail;
        beats = 0; pat_bad = 0; hold_bad = 0; dones = 0; late_valid = 0;
        held_d = '0; held_l = 1'b0; stalled = 0; phase = 1; tail = 0;
        @(negedge clock);
        beat_count = CW'(n);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 4*n + 50; cyc++) begin
            if (abort_at >= 0 && beats == abort_at) break;
            if (cyc == restart_at) start = 1'b1;
            else if (cyc == restart_at + 1) start = 1'b0;
            gate = toggle ? phase : 1'b1;
            phase = ~phase;
            corrupt_now = (beats == corrupt_at);
            #1;
            if (tx_done) dones++;
            if (stalled && (out_tdata !== held_d || out_tlast !== held_l)) hold_bad++;
            stalled = 0;
            if (beats == n) begin
                if (out_tvalid) late_valid++;
                tail++;
                if (tail == 4) break;
            end else if (out_tvalid) begin
                if (out_tready) begin
                    for (int l = 0; l < DW/32; l++)
                        if (out_tdata[l*32 +: 32] !== 32'(beats + l)) pat_bad++;
                    if (out_tlast !== (beats == n - 1)) pat_bad++;
                    beats++;
                end else begin
                    stalled = 1;
                    held_d = out_tdata;
                    held_l = out_tlast;
                end
            end
            @(negedge clock);
        end
        corrupt_now = 1'b0;
        gate = 1'b1;
    endtask

    initial begin
        int beats, pat_bad, hold_bad, dones, late_valid;
        mask = '0;
        mask[96] = 1'b1;

        // Reset state
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_done", 64'(tx_done), 64'd0);
        check("rst_xfer_time", xfer_time, 64'd0);
        check("rst_rx_beats", 64'(rx_beats), 64'd0);
        check("rst_rx_errors", 64'(rx_errors), 64'd0);
        check("rst_rx_first_err", 64'(rx_first_err), 64'hFFFF_FFFF);
        check("rst_in_tready", 64'(in_tready), 64'd0);
        check("rst_tdata", 64'(out_tdata[63:0]), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        check("tready_after_release", 64'(in_tready), 64'd1);

        // 500 beats, link always ready
        burst(500, 0, -1, -1, -1, beats, pat_bad, hold_bad, dones, late_valid);
        check("b500_beats", 64'(beats), 64'd500);
        check("b500_pattern", 64'(pat_bad), 64'd0);
        check("b500_tx_done_pulses", 64'(dones), 64'd1);
        check("b500_xfer_time", xfer_time, 64'd500);
        check("b500_no_extra_valid", 64'(late_valid), 64'd0);
        check("b500_busy_after", 64'(busy), 64'd0);
        check("b500_rx_beats", 64'(rx_beats), 64'd500);
        check("b500_rx_errors", 64'(rx_errors), 64'd0);
        check("b500_rx_first_err", 64'(rx_first_err), 64'hFFFF_FFFF);
        check("b500_rx_time", rx_time, 64'd500);

        // Same burst, ready toggling every cycle
        burst(500, 1, -1, -1, -1, beats, pat_bad, hold_bad, dones, late_valid);
        check("tog_beats", 64'(beats), 64'd500);
        check("tog_pattern", 64'(pat_bad), 64'd0);
        check("tog_hold", 64'(hold_bad), 64'd0);
        check("tog_xfer_time", xfer_time, 64'd999);
        check("tog_rx_beats", 64'(rx_beats), 64'd500);
        check("tog_rx_time", rx_time, 64'd999);

        // Loopback with beat 37 lane 3 corrupted
        burst(500, 0, 37, -1, -1, beats, pat_bad, hold_bad, dones, late_valid);
        check("cor_rx_beats", 64'(rx_beats), 64'd500);
        check("cor_rx_errors", 64'(rx_errors), EXP_CORR_ERRS);
        check("cor_rx_first_err", 64'(rx_first_err), EXP_CORR_FIRST);
        check("cor_rx_time", rx_time, 64'd500);
        check("cor_xfer_time", xfer_time, 64'd500);

        // Zero-length burst
        @(negedge clock);
        beat_count = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        check("zero_tx_done", 64'(tx_done), 64'd1);
        check("zero_tvalid", 64'(out_tvalid), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_xfer_time", xfer_time, 64'd0);
        @(negedge clock);
        #1;
        check("zero_tx_done_drop", 64'(tx_done), 64'd0);
        check("zero_tvalid_after", 64'(out_tvalid), 64'd0);

        // Second start edge while busy is ignored
        burst(100, 0, -1, 10, -1, beats, pat_bad, hold_bad, dones, late_valid);
        check("rs_beats", 64'(beats), 64'd100);
        check("rs_pattern", 64'(pat_bad), 64'd0);
        check("rs_no_extra_valid", 64'(late_valid), 64'd0);
        check("rs_tx_done_pulses", 64'(dones), 64'd1);
        check("rs_xfer_time", xfer_time, 64'd100);

        // Reset in the middle of a burst at beat 200
        burst(500, 0, -1, -1, 200, beats, pat_bad, hold_bad, dones, late_valid);
        check("ab_reached_200", 64'(beats), 64'd200);
        check("ab_busy_before", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        check("ab_tvalid", 64'(out_tvalid), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_xfer_time", xfer_time, 64'd0);
        check("ab_rx_beats", 64'(rx_beats), 64'd0);
        check("ab_rx_time", rx_time, 64'd0);
        check("ab_rx_first_err", 64'(rx_first_err), 64'hFFFF_FFFF);
        check("ab_in_tready", 64'(in_tready), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        check("ab_tready_back", 64'(in_tready), 64'd1);

        // Clean burst after the reset restarts from beat 0
        burst(20, 0, -1, -1, -1, beats, pat_bad, hold_bad, dones, late_valid);
        check("post_beats", 64'(beats), 64'd20);
        check("post_pattern", 64'(pat_bad), 64'd0);
        check("post_xfer_time", xfer_time, 64'd20);
        check("post_rx_beats", 64'(rx_beats), 64'd20);
        check("post_rx_errors", 64'(rx_errors), 64'd0);
        check("post_rx_time", rx_time, 64'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
